elevator_sched: RTL and testbench
=================================

ELEVATOR_SCHED -- requirements
Module: elevator_sched

Interface
REQ-001 SHALL have parameter FLOORS, default 4, number of floors, 2..8.
REQ-002 SHALL have parameter MOVE_TICKS, default 100000000, clk cycles per one-floor move (2 s).
REQ-003 SHALL have parameter DOOR_TICKS, default 150000000, clk cycles door stays open (3 s).
REQ-004 SHALL have port clk  in  1  system clock; one clock domain only, all logic on posedge clk.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port req  in  FLOORS  level, OR of latched cabin and hall requests, bit i = floor i+1.
REQ-007 SHALL have port clr  out  FLOORS  one-cycle pulse per bit, clears the serviced request latch.
REQ-008 SHALL have port floor  out  3  current floor index, 0-based.
REQ-009 SHALL have port dir_up  out  1  1 = last/current travel direction up.
REQ-010 SHALL have port moving  out  1  high in MOVE_UP/MOVE_DN.
REQ-011 SHALL have port door_open  out  1  high in DOOR.
REQ-012 SHALL have port state  out  2  FSM state code (IDLE=0, MOVE_UP=1, MOVE_DN=2, DOOR=3).

Function
REQ-013 SHALL implement FSM states IDLE, MOVE_UP, MOVE_DN, DOOR; all outputs registered.
REQ-014 SHALL, in IDLE with req[floor]=1, enter DOOR next cycle and pulse clr[floor] on that same edge.
REQ-015 SHALL, in IDLE with no request at floor, pick direction: keep dir_up if any request lies that way, else reverse if any request the other way, else stay IDLE.
REQ-016 SHALL, on entering MOVE_x, load move timer with MOVE_TICKS; on expiry floor +/-1 and timer reloads.
REQ-017 SHALL, on arrival (floor update edge), decide next cycle: req[new floor]=1 -> DOOR with clr pulse; else continue if requests remain ahead; else IDLE.
REQ-018 SHALL never increment floor past FLOORS-1 nor decrement below 0; MOVE_UP at top or MOVE_DN at bottom forces IDLE.
REQ-019 SHALL, in DOOR, load door timer with DOOR_TICKS; on expiry go to IDLE (re-evaluate next cycle).
REQ-020 SHALL, if req[floor] rises while in DOOR, pulse clr[floor] and reload door timer.
REQ-021 SHALL, with requests both above and below in IDLE, honour current dir_up (up wins when dir_up=1).
REQ-022 SHALL ignore req bits while moving between floors except for the direction/arrival decisions above.
REQ-023 SHALL use timer width ceil(log2(max(MOVE_TICKS,DOOR_TICKS)+1)); no wrap-around permitted.

Reset
REQ-024 SHALL on rst_n=0 force state=IDLE, floor=0, dir_up=1, clr=0, moving=0, door_open=0, timers=0, immediately.
REQ-025 SHALL, if reset hits mid-move or mid-door, abandon operation; no clr pulse generated.

Configuration
REQ-026 SHALL, with DOOR_HOLD_EN defined, add input door_hold (1 bit); while high in DOOR, door timer holds at DOOR_TICKS and door_open stays 1.
REQ-027 SHALL, without DOOR_HOLD_EN, have no door_hold port and behaviour exactly per REQ-019.

Structure
REQ-028 SHALL take state encoding type and FLOORS default from shared package elevator_pkg.
REQ-029 SHALL instantiate sub-module tick_timer (load, count value, done pulse) twice: move and door timers.

Verification (FLOORS=4, MOVE_TICKS=4, DOOR_TICKS=6)
REQ-030 SHALL cover: reset, req=4'b0001 -> next cycle clr=4'b0001, door_open=1 for 6 cycles, then IDLE.
REQ-031 SHALL cover: floor 0, req=4'b1000 -> MOVE_UP, floor 1,2,3 at 4-cycle steps, DOOR at 3 with clr=4'b1000.
REQ-032 SHALL cover: floor 1 dir_up=1, req=4'b1001 -> goes up to 3 first, then down to 0.
REQ-033 SHALL cover: in DOOR at floor 2, req[2] re-asserted at door cycle 4 -> clr pulse, door stays open 6 more cycles.
REQ-034 SHALL cover: rst_n low during MOVE_UP at floor 2 -> floor=0, state=IDLE, clr=0 same cycle.
REQ-035 SHALL cover (DOOR_HOLD_EN): door_hold=1 for 20 cycles in DOOR -> door_open=1 throughout, closes 6 cycles after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler: state encoding, default floor
// count and timer sizing.
package elevator_pkg;

   localparam int FLOORS_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MOVE_UP = 2'd1,
      ST_MOVE_DN = 2'd2,
      ST_DOOR    = 2'd3
   } state_t;

   // Wide enough to hold the larger of the two reload values without wrapping.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/elevator_sched_tick_timer.sv
// Down-counting tick timer: load sets the count, done flags the final tick
// before the count reaches zero; the count parks at zero.
module tick_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/elevator_sched.sv
// Elevator scheduler: single-car floor sequencing with move and door timers.
// Optional door_hold input is compiled in when DOOR_HOLD_EN is defined.
//   state   | meaning
//   IDLE    | parked, choosing between door, up, down or staying put
//   MOVE_UP | travelling upward, one floor per move-timer expiry
//   MOVE_DN | travelling downward, one floor per move-timer expiry
//   DOOR    | door open at current floor until door timer expires
module elevator_sched
   import elevator_pkg::*;
#(
   parameter int FLOORS     = FLOORS_DEF,
   parameter int MOVE_TICKS = 100000000,
   parameter int DOOR_TICKS = 150000000
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef DOOR_HOLD_EN
   input  logic              door_hold,
`endif
   input  logic [FLOORS-1:0] req,
   output logic [FLOORS-1:0] clr,
   output logic [2:0]        floor,
   output logic              dir_up,
   output logic              moving,
   output logic              door_open,
   output logic [1:0]        state
);

   localparam int         TW        = timer_width(MOVE_TICKS, DOOR_TICKS);
   localparam logic [2:0] FLOOR_TOP = 3'(FLOORS - 1);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_floor;
   logic              r_dir_up, r_moving, r_door_open, r_arrived;
   logic [FLOORS-1:0] r_clr, r_req_prev, w_here_oh, w_clr_nxt;
   logic              w_here, w_rise, w_above, w_below, w_hold;
   logic              w_mv_done, w_door_done, w_mv_load, w_door_load, w_step;

`ifdef DOOR_HOLD_EN
   assign w_hold = door_hold;
`else
   assign w_hold = 1'b0;
`endif

   always_comb begin
      w_here_oh = '0;
      w_above   = 1'b0;
      w_below   = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (3'(i) == r_floor) w_here_oh[i] = 1'b1;
         if (3'(i) > r_floor)  w_above = w_above | req[i];
         if (3'(i) < r_floor)  w_below = w_below | req[i];
      end
   end

   assign w_here = |(req & w_here_oh);
   assign w_rise = |(req & ~r_req_prev & w_here_oh);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_here)                    w_state_nxt = ST_DOOR;
            else if (r_dir_up && w_above)  w_state_nxt = ST_MOVE_UP;
            else if (!r_dir_up && w_below) w_state_nxt = ST_MOVE_DN;
            else if (w_above)              w_state_nxt = ST_MOVE_UP;
            else if (w_below)              w_state_nxt = ST_MOVE_DN;
         end
         ST_MOVE_UP: begin
            if (r_arrived) begin
               if (w_here)        w_state_nxt = ST_DOOR;
               else if (!w_above) w_state_nxt = ST_IDLE;
            end else if (w_mv_done && r_floor == FLOOR_TOP) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MOVE_DN: begin
            if (r_arrived) begin
               if (w_here)        w_state_nxt = ST_DOOR;
               else if (!w_below) w_state_nxt = ST_IDLE;
            end else if (w_mv_done && r_floor == 3'd0) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DOOR: begin
            // A fresh request at this floor or a held door keeps it open.
            if (!w_rise && !w_hold && w_door_done) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_step      = ((r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DN)) &&
                    (w_state_nxt == r_state) && w_mv_done;
      w_mv_load   = w_step || ((r_state == ST_IDLE) &&
                    ((w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DN)));
      w_door_load = (w_state_nxt == ST_DOOR) &&
                    ((r_state != ST_DOOR) || w_rise || w_hold);
      w_clr_nxt   = '0;
      if ((w_state_nxt == ST_DOOR) && ((r_state != ST_DOOR) || w_rise))
         w_clr_nxt = w_here_oh;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_floor     <= 3'd0;
         r_dir_up    <= 1'b1;
         r_clr       <= '0;
         r_moving    <= 1'b0;
         r_door_open <= 1'b0;
         r_arrived   <= 1'b0;
         r_req_prev  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr       <= w_clr_nxt;
         r_moving    <= (w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DN);
         r_door_open <= (w_state_nxt == ST_DOOR);
         r_arrived   <= w_step;
         r_req_prev  <= req;
         if (w_step)
            r_floor <= (r_state == ST_MOVE_UP) ? r_floor + 3'd1 : r_floor - 3'd1;
         if (r_state == ST_IDLE && w_state_nxt == ST_MOVE_UP) r_dir_up <= 1'b1;
         if (r_state == ST_IDLE && w_state_nxt == ST_MOVE_DN) r_dir_up <= 1'b0;
      end
   end

   tick_timer #(.W(TW)) u_move_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_mv_load),
      .i_load_val (TW'(MOVE_TICKS)),
      .o_done     (w_mv_done)
   );

   tick_timer #(.W(TW)) u_door_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_door_load),
      .i_load_val (TW'(DOOR_TICKS)),
      .o_done     (w_door_done)
   );

   assign state     = r_state;
   assign floor     = r_floor;
   assign dir_up    = r_dir_up;
   assign clr       = r_clr;
   assign moving    = r_moving;
   assign door_open = r_door_open;

endmodule

// File: tb/tb_elevator_sched.sv
// Bench for elevator_sched (FLOORS=4, MOVE_TICKS=4, DOOR_TICKS=6) with a
// request-latch emulation and a rule-level reference model of the car.
module tb_elevator_sched;

   localparam int FL = 4;
   localparam int MT = 4;
   localparam int DT = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        door_hold;
   logic [3:0]  req, clr;
   logic [2:0]  floor;
   logic        dir_up, moving, door_open;
   logic [1:0]  state;
   logic [11:0] obs;

   int total = 0;
   int bad   = 0;

   // reference model: 0 idle, 1 up, 2 down, 3 door
   int         m_state, m_floor, m_mv_left, m_door_left;
   bit         m_dir, m_arr;
   logic [3:0] m_clr, m_prev, latch;

   elevator_sched #(.FLOORS(FL), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef DOOR_HOLD_EN
      .door_hold (door_hold),
`endif
      .req       (req),
      .clr       (clr),
      .floor     (floor),
      .dir_up    (dir_up),
      .moving    (moving),
      .door_open (door_open),
      .state     (state)
   );

   always #5 clk = ~clk;

   assign obs = {state, floor, dir_up, moving, door_open, clr};

   function automatic logic [11:0] exp_vec();
      logic mv, dr;
      mv = (m_state == 1) || (m_state == 2);
      dr = (m_state == 3);
      return {2'(m_state), 3'(m_floor), m_dir, mv, dr, m_clr};
   endfunction

   task automatic model_reset();
      m_state = 0; m_floor = 0; m_dir = 1'b1; m_arr = 1'b0;
      m_mv_left = 0; m_door_left = 0; m_clr = '0; m_prev = '0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic h);
      bit here, above, below, rise, arr_now, up, ahead, go_on;
      logic [3:0] nclr;
      here = 0; above = 0; below = 0; rise = 0; arr_now = 0; nclr = '0;
      for (int j = 0; j < FL; j++) begin
         if (j > m_floor) above = above | r[j];
         if (j < m_floor) below = below | r[j];
         if (j == m_floor) begin
            here = r[j];
            rise = r[j] & ~m_prev[j];
         end
      end
      if (m_state == 0) begin
         if (here) begin
            m_state = 3; nclr[m_floor] = 1'b1; m_door_left = DT;
         end else if ((m_dir && above) || (!m_dir && !below && above)) begin
            m_state = 1; m_dir = 1'b1; m_mv_left = MT;
         end else if (below) begin
            m_state = 2; m_dir = 1'b0; m_mv_left = MT;
         end
      end else if (m_state == 1 || m_state == 2) begin
         up = (m_state == 1);
         ahead = up ? above : below;
         go_on = 1;
         if (m_arr) begin
            if (here) begin
               m_state = 3; nclr[m_floor] = 1'b1; m_door_left = DT; go_on = 0;
            end else if (!ahead) begin
               m_state = 0; go_on = 0;
            end
         end
         if (go_on) begin
            m_mv_left--;
            if (m_mv_left == 0) begin
               if ((up && m_floor == FL - 1) || (!up && m_floor == 0)) begin
                  m_state = 0;
               end else begin
                  m_floor = up ? m_floor + 1 : m_floor - 1;
                  m_mv_left = MT;
                  arr_now = 1;
               end
            end
         end
      end else begin
         if (rise) begin
            nclr[m_floor] = 1'b1; m_door_left = DT;
         end else if (h) begin
            m_door_left = DT;
         end else begin
            m_door_left--;
            if (m_door_left == 0) m_state = 0;
         end
      end
      m_clr = nclr;
      m_arr = arr_now;
      m_prev = r;
   endtask

   // One clock: DUT and model both see the current req; the emulated request
   // latch then drops the bits cleared by the previous cycle's clr pulse.
   task automatic tick();
      logic [3:0] old_clr;
      @(posedge clk);
      #1;
      old_clr = m_clr;
      model_step(req, door_hold);
      latch = latch & ~old_clr;
      req = latch;
   endtask

   task automatic add_req(input logic [3:0] b);
      latch = latch | b;
      req = latch;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      latch = '0;
      req = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; door_hold = 1'b0; latch = '0; req = '0;
      model_reset();
      #12;
      total++;
      if (obs !== 12'b00_000_1_0_0_0000) begin
         bad++; $display("FAIL reset_values got=%b want=%b", obs, 12'b00_000_1_0_0_0000);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      total++;
      if (obs !== exp_vec()) begin
         bad++; $display("FAIL reset_idle got=%b want=%b", obs, exp_vec());
      end
   endtask

   task automatic test_door_here();
      int n_open;
      bit done;
      add_req(4'b0001);
      tick();
      total++;
      if (clr !== 4'b0001 || door_open !== 1'b1) begin
         bad++; $display("FAIL door_here_entry clr=%b open=%b want clr=0001 open=1", clr, door_open);
      end
      n_open = 1; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL door_here_cycle got=%b want=%b", obs, exp_vec());
         end
         if (door_open) n_open++; else done = 1;
      end
      total++;
      if (!done || n_open != DT || state !== 2'd0) begin
         bad++; $display("FAIL door_here_len open_cycles=%0d state=%0d want %0d and 0", n_open, state, DT);
      end
   endtask

   task automatic test_move_up();
      int t_arr[4];
      int t_door, door_fl;
      for (int i = 0; i < 4; i++) t_arr[i] = -1;
      t_door = -1; door_fl = -1;
      add_req(4'b1000);
      for (int t = 1; t <= 40 && t_door < 0; t++) begin
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL move_up_cycle t=%0d got=%b want=%b", t, obs, exp_vec());
         end
         if (t_arr[floor] < 0) t_arr[floor] = t;
         if (clr !== 4'b0000) begin
            t_door = t; door_fl = floor;
            total++;
            if (clr !== 4'b1000) begin
               bad++; $display("FAIL move_up_clr got=%b want=1000", clr);
            end
         end
      end
      total++;
      if (t_arr[1] != 5 || t_arr[2] != 9 || t_arr[3] != 13 || t_door != 14 || door_fl != 3) begin
         bad++;
         $display("FAIL move_up_timing f1=%0d f2=%0d f3=%0d door=%0d@%0d want 5 9 13 14@3",
                  t_arr[1], t_arr[2], t_arr[3], t_door, door_fl);
      end
      for (int k = 0; k < 20 && m_state != 0; k++) tick();
   endtask

   task automatic test_up_then_down();
      int dq[$];
      bit fin;
      do_reset();
      add_req(4'b0010);
      fin = 0;
      for (int k = 0; k < 40 && !fin; k++) begin
         tick();
         if (k > 0 && m_state == 0 && latch == 4'b0) fin = 1;
      end
      total++;
      if (floor !== 3'd1 || dir_up !== 1'b1 || state !== 2'd0) begin
         bad++; $display("FAIL updown_start floor=%0d dir=%b state=%0d want 1 1 0", floor, dir_up, state);
      end
      add_req(4'b1001);
      fin = 0;
      for (int k = 0; k < 100 && !fin; k++) begin
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL updown_cycle got=%b want=%b", obs, exp_vec());
         end
         if (clr !== 4'b0000) dq.push_back(int'(floor));
         if (m_state == 0 && latch == 4'b0) fin = 1;
      end
      total++;
      if (!fin || dq.size() != 2 || dq[0] != 3 || dq[1] != 0) begin
         bad++; $display("FAIL updown_order doors=%0d first=%0d want 2 doors 3 then 0",
                         dq.size(), (dq.size() > 0) ? dq[0] : -1);
      end
   endtask

   task automatic test_door_reassert();
      int n_open;
      bit done;
      add_req(4'b0100);
      for (int k = 0; k < 40 && m_state != 3; k++) begin
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL reassert_travel got=%b want=%b", obs, exp_vec());
         end
      end
      repeat (3) tick();
      total++;
      if (door_open !== 1'b1 || floor !== 3'd2) begin
         bad++; $display("FAIL reassert_pre open=%b floor=%0d want 1 2", door_open, floor);
      end
      add_req(4'b0100);
      tick();
      total++;
      if (clr !== 4'b0100 || obs !== exp_vec()) begin
         bad++; $display("FAIL reassert_clr got=%b want=%b", obs, exp_vec());
      end
      n_open = 1; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL reassert_cycle got=%b want=%b", obs, exp_vec());
         end
         if (door_open) n_open++; else done = 1;
      end
      total++;
      if (!done || n_open != DT) begin
         bad++; $display("FAIL reassert_len open_cycles=%0d want %0d", n_open, DT);
      end
   endtask

   task automatic test_reset_mid_move();
      add_req(4'b1000);
      repeat (3) tick();
      total++;
      if (state !== 2'd1 || floor !== 3'd2 || obs !== exp_vec()) begin
         bad++; $display("FAIL midmove_pre got=%b want=%b", obs, exp_vec());
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs !== 12'b00_000_1_0_0_0000) begin
         bad++; $display("FAIL midmove_async got=%b want=%b", obs, 12'b00_000_1_0_0_0000);
      end
      latch = '0; req = '0;
      model_reset();
      @(posedge clk);
      #1;
      total++;
      if (clr !== 4'b0 || state !== 2'd0 || floor !== 3'd0) begin
         bad++; $display("FAIL midmove_held clr=%b state=%0d floor=%0d want 0 0 0", clr, state, floor);
      end
      rst_n = 1'b1;
      repeat (2) begin
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL midmove_after got=%b want=%b", obs, exp_vec());
         end
      end
   endtask

`ifdef DOOR_HOLD_EN
   task automatic test_door_hold();
      int n;
      bit done;
      add_req(4'(1) << m_floor);
      tick();
      door_hold = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         total++;
         if (door_open !== 1'b1 || obs !== exp_vec()) begin
            bad++; $display("FAIL hold_open k=%0d got=%b want=%b", k, obs, exp_vec());
         end
      end
      door_hold = 1'b0;
      n = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         n++;
         if (!door_open) done = 1;
      end
      total++;
      if (!done || n != DT) begin
         bad++; $display("FAIL hold_release close_after=%0d want %0d", n, DT);
      end
   endtask
`endif

   task automatic test_random();
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 5) == 0) add_req(4'(1) << $urandom_range(0, 3));
         tick();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_door_here();
      test_move_up();
      test_up_then_down();
      test_door_reassert();
      test_reset_mid_move();
`ifdef DOOR_HOLD_EN
      test_door_hold();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
